// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, non-stalling memory between an instruction-fetch
// port and a load/store port. Arbitration is combinational in the request
// cycle: the data port normally wins a conflict, but once the instruction
// port has been refused MAX_WAIT consecutive times it is forced to win. The
// memory returns read data exactly one cycle after it accepts a request, so
// a small response FSM remembers who was granted and routes the returned
// data (or a store acknowledge) back to that port one cycle later.
//
// Parameters
//   MAX_WAIT        consecutive instruction-port refusals before it must win
//                   (legal range 1..15)
//
// Ports
//   clk_i           clock, all state updates on the rising edge
//   reset_i         asynchronous active-high reset
//   instr_req_i     fetch request
//   instr_addr_i    fetch byte address
//   instr_gnt_o     fetch accepted this cycle
//   instr_rvalid_o  fetch data valid
//   instr_rdata_o   fetch data
//   data_req_i      load/store request
//   data_we_i       1 = store, 0 = load
//   data_addr_i     load/store byte address
//   data_wdata_i    store data
//   data_gnt_o      load/store accepted this cycle
//   data_rvalid_o   load data valid or store acknowledged
//   data_rdata_o    load data (0 on store acknowledge)
//   mem_req_o       request to the shared memory
//   mem_we_o        memory write enable
//   mem_addr_o      memory address
//   mem_wdata_o     memory write data
//   mem_rdata_i     memory read data, valid one cycle after an accepted read
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        RESP_I,
        RESP_DR,
        RESP_DW
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
    localparam logic [3:0] WAIT_SAT   = 4'd15;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_next;
    logic       instr_sel;
    logic       data_sel;

    // -------------------------------------------------------------------------
    // Arbitration and memory request mux
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before any branch, so no
    // path through the block leaves a value unassigned and no latch appears.
    always_comb begin
        instr_sel   = 1'b0;
        data_sel    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        // A lone requester always wins; on a conflict the data port wins
        // until the instruction port has been starved long enough.
        if (instr_req_i && (!data_req_i || (wait_cnt >= WAIT_LIMIT))) begin
            instr_sel = 1'b1;
        end else if (data_req_i) begin
            data_sel = 1'b1;
        end

        if (instr_sel) begin
            mem_addr_o = instr_addr_i;
        end else if (data_sel) begin
            mem_we_o    = data_we_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign instr_gnt_o = instr_sel;
    assign data_gnt_o  = data_sel;
    assign mem_req_o   = instr_req_i | data_req_i;

    // -------------------------------------------------------------------------
    // Starvation counter: counts consecutive refused fetch cycles; any cycle
    // where the fetch port is served or idle starts the count over.
    // -------------------------------------------------------------------------
    always_comb begin
        wait_cnt_next = '0;
        if (instr_req_i && !instr_sel) begin
            wait_cnt_next = (wait_cnt == WAIT_SAT) ? WAIT_SAT : wait_cnt + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Response FSM: next state is fully determined by this cycle's grant, so
    // back-to-back grants produce back-to-back responses with no bubble.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = IDLE;
        if (instr_sel) begin
            state_next = RESP_I;
        end else if (data_sel) begin
            state_next = data_we_i ? RESP_DW : RESP_DR;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its input from before the edge, independent of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Response routing. Memory read data is passed straight through in the
    // cycle after the grant; a store acknowledge carries zero data. Reset
    // forces the FSM to IDLE, which drops any response still in flight.
    // -------------------------------------------------------------------------
    always_comb begin
        instr_rvalid_o = 1'b0;
        instr_rdata_o  = '0;
        data_rvalid_o  = 1'b0;
        data_rdata_o   = '0;
        unique case (state)
            RESP_I: begin
                instr_rvalid_o = 1'b1;
                instr_rdata_o  = mem_rdata_i;
            end
            RESP_DR: begin
                data_rvalid_o = 1'b1;
                data_rdata_o  = mem_rdata_i;
            end
            RESP_DW: begin
                data_rvalid_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiters (MAX_WAIT = 4 and MAX_WAIT = 1) share the same stimulus. A
// behavioural model tracks, per instance, how many times in a row the fetch
// port has been refused and which port (if any) is owed a response next
// cycle; expected outputs are derived from those two facts.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] mem_rdata;

    // Index 0: MAX_WAIT = 4, index 1: MAX_WAIT = 1.
    logic        igt   [2];
    logic        irv   [2];
    logic [31:0] ird   [2];
    logic        dgt   [2];
    logic        drv   [2];
    logic [31:0] drd   [2];
    logic        mreq  [2];
    logic        mwe   [2];
    logic [31:0] maddr [2];
    logic [31:0] mwdata[2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_WAIT(4)) u_dut4 (
        .clk_i(clk), .reset_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(igt[0]), .instr_rvalid_o(irv[0]), .instr_rdata_o(ird[0]),
        .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata),
        .data_gnt_o(dgt[0]), .data_rvalid_o(drv[0]), .data_rdata_o(drd[0]),
        .mem_req_o(mreq[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]),
        .mem_wdata_o(mwdata[0]), .mem_rdata_i(mem_rdata)
    );

    mem_arbiter #(.MAX_WAIT(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(igt[1]), .instr_rvalid_o(irv[1]), .instr_rdata_o(ird[1]),
        .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata),
        .data_gnt_o(dgt[1]), .data_rvalid_o(drv[1]), .data_rdata_o(drd[1]),
        .mem_req_o(mreq[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]),
        .mem_wdata_o(mwdata[1]), .mem_rdata_i(mem_rdata)
    );

    // ---------------------------------------------------------------- model --
    int          mw     [2] = '{4, 1};
    int          refused[2];           // consecutive refused fetch cycles
    int          owed   [2];           // 0 none, 1 fetch, 2 load, 3 store
    logic        e_igt  [2];
    logic        e_dgt  [2];
    logic        e_mreq [2];
    logic        e_mwe  [2];
    logic [31:0] e_maddr[2];
    logic [31:0] e_mwd  [2];
    logic        e_irv  [2];
    logic [31:0] e_ird  [2];
    logic        e_drv  [2];
    logic [31:0] e_drd  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            refused[k] = 0;
            owed[k]    = 0;
        end
    endtask

    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            bit fetch_wins;
            fetch_wins = instr_req && (!data_req || refused[k] >= mw[k]);
            e_igt[k]   = fetch_wins;
            e_dgt[k]   = data_req && !fetch_wins;
            e_mreq[k]  = instr_req || data_req;
            e_maddr[k] = fetch_wins ? instr_addr : (data_req ? data_addr : 32'h0);
            e_mwe[k]   = e_dgt[k] && data_we;
            e_mwd[k]   = e_dgt[k] ? data_wdata : 32'h0;
            e_irv[k]   = (owed[k] == 1);
            e_ird[k]   = (owed[k] == 1) ? mem_rdata : 32'h0;
            e_drv[k]   = (owed[k] == 2) || (owed[k] == 3);
            e_drd[k]   = (owed[k] == 2) ? mem_rdata : 32'h0;
        end
    endtask

    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                refused[k] = 0;
                owed[k]    = 0;
            end else begin
                owed[k] = e_igt[k] ? 1 : (e_dgt[k] ? (data_we ? 3 : 2) : 0);
                if (instr_req && !e_igt[k])
                    refused[k] = (refused[k] + 1 > 15) ? 15 : refused[k] + 1;
                else
                    refused[k] = 0;
            end
        end
    endtask

    // --------------------------------------------------------- sequencing --
    // Inputs change 1 ns after a rising edge; outputs are sampled on the
    // falling edge.
    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        instr_req  = 1'b0;
        instr_addr = 32'h0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
    endtask

    // ---------------------------------------------------------------- tests --
    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        idle_inputs();
        mem_rdata = 32'hFFFF_FFFF;
        settle();
        for (int k = 0; k < 2; k++) begin
            total++; if (irv[k] !== 1'b0 || drv[k] !== 1'b0) begin bad++;
                $display("FAIL reset_rvalid[%0d]: got i=%b d=%b want 0 0", k, irv[k], drv[k]); end
            total++; if (ird[k] !== 32'h0 || drd[k] !== 32'h0) begin bad++;
                $display("FAIL reset_rdata[%0d]: got i=%h d=%h want 0", k, ird[k], drd[k]); end
            total++; if (mreq[k] !== 1'b0 || igt[k] !== 1'b0 || dgt[k] !== 1'b0) begin bad++;
                $display("FAIL reset_idle_gnt[%0d]: got req=%b ig=%b dg=%b want 0", k, mreq[k], igt[k], dgt[k]); end
        end
        // Grants stay live during reset, with the starvation count held at 0.
        @(posedge clk); #1;
        instr_req = 1'b1; instr_addr = 32'h0000_0040;
        data_req  = 1'b1; data_addr  = 32'h0000_1000;
        repeat (3) begin
            settle();
            for (int k = 0; k < 2; k++) begin
                total++; if (dgt[k] !== 1'b1 || igt[k] !== 1'b0 || maddr[k] !== 32'h1000) begin bad++;
                    $display("FAIL reset_gnt[%0d]: got dg=%b ig=%b addr=%h want 1 0 1000", k, dgt[k], igt[k], maddr[k]); end
                total++; if (drv[k] !== 1'b0) begin bad++;
                    $display("FAIL reset_no_resp[%0d]: got %b want 0", k, drv[k]); end
            end
            tick();
        end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        instr_req = 1'b1; instr_addr = 32'h0000_0100;
        settle();
        total++; if (igt[0] !== 1'b1 || dgt[0] !== 1'b0 || mreq[0] !== 1'b1) begin bad++;
            $display("FAIL fetch_gnt: got ig=%b dg=%b req=%b want 1 0 1", igt[0], dgt[0], mreq[0]); end
        total++; if (maddr[0] !== 32'h100 || mwe[0] !== 1'b0 || mwdata[0] !== 32'h0) begin bad++;
            $display("FAIL fetch_mem: got addr=%h we=%b wd=%h want 100 0 0", maddr[0], mwe[0], mwdata[0]); end
        tick();
        idle_inputs();
        mem_rdata = 32'h0000_0013;
        settle();
        total++; if (irv[0] !== 1'b1 || ird[0] !== 32'h13 || drv[0] !== 1'b0) begin bad++;
            $display("FAIL fetch_resp: got iv=%b id=%h dv=%b want 1 13 0", irv[0], ird[0], drv[0]); end
        tick();
        settle();
        total++; if (irv[0] !== 1'b0) begin bad++;
            $display("FAIL fetch_single: got %b want 0", irv[0]); end
        tick();
    endtask

    task automatic test_contention();
        bit prev_i4;
        bit prev_i1;
        instr_req = 1'b1; instr_addr = 32'h0000_0040;
        data_req  = 1'b1; data_we    = 1'b0; data_addr = 32'h0000_2000;
        for (int c = 0; c < 10; c++) begin
            bit want_i4;
            bit want_i1;
            want_i4   = (c == 4) || (c == 9);
            want_i1   = (c % 2) == 1;
            mem_rdata = $urandom;
            settle();
            total++; if (igt[0] !== want_i4 || dgt[0] !== !want_i4) begin bad++;
                $display("FAIL starve4_gnt c%0d: got ig=%b dg=%b want %b %b", c, igt[0], dgt[0], want_i4, !want_i4); end
            total++; if (igt[1] !== want_i1 || dgt[1] !== !want_i1) begin bad++;
                $display("FAIL alt1_gnt c%0d: got ig=%b dg=%b want %b %b", c, igt[1], dgt[1], want_i1, !want_i1); end
            if (c > 0) begin
                total++; if (irv[0] !== prev_i4 || drv[0] !== !prev_i4) begin bad++;
                    $display("FAIL starve4_resp c%0d: got iv=%b dv=%b want %b %b", c, irv[0], drv[0], prev_i4, !prev_i4); end
                total++; if (drd[1] !== (prev_i1 ? 32'h0 : mem_rdata)) begin bad++;
                    $display("FAIL alt1_rdata c%0d: got %h want %h", c, drd[1], prev_i1 ? 32'h0 : mem_rdata); end
            end
            prev_i4 = want_i4;
            prev_i1 = want_i1;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_store();
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_2004; data_wdata = 32'hDEAD_BEEF;
        settle();
        total++; if (dgt[0] !== 1'b1 || mwe[0] !== 1'b1) begin bad++;
            $display("FAIL store_gnt: got dg=%b we=%b want 1 1", dgt[0], mwe[0]); end
        total++; if (maddr[0] !== 32'h2004 || mwdata[0] !== 32'hDEAD_BEEF) begin bad++;
            $display("FAIL store_mem: got addr=%h wd=%h want 2004 deadbeef", maddr[0], mwdata[0]); end
        tick();
        idle_inputs();
        mem_rdata = 32'hA5A5_5A5A;
        settle();
        total++; if (drv[0] !== 1'b1 || drd[0] !== 32'h0 || irv[0] !== 1'b0) begin bad++;
            $display("FAIL store_ack: got dv=%b dd=%h iv=%b want 1 0 0", drv[0], drd[0], irv[0]); end
        tick();
    endtask

    task automatic test_back_to_back();
        int rv_count = 0;
        for (int c = 0; c <= 8; c++) begin
            idle_inputs();
            if (c < 8) begin
                if (c % 2 == 0) begin
                    instr_req = 1'b1; instr_addr = 32'h100 + 32'(4 * c);
                end else begin
                    data_req = 1'b1; data_addr = 32'h3000 + 32'(4 * c);
                end
            end
            mem_rdata = $urandom;
            settle();
            if (c < 8) begin
                total++; if (igt[0] !== (c % 2 == 0) || dgt[0] !== (c % 2 == 1)) begin bad++;
                    $display("FAIL b2b_gnt c%0d: got ig=%b dg=%b", c, igt[0], dgt[0]); end
            end
            if (c > 0) begin
                bit was_fetch;
                was_fetch = ((c - 1) % 2 == 0);
                total++; if (irv[0] !== was_fetch || drv[0] !== !was_fetch) begin bad++;
                    $display("FAIL b2b_resp c%0d: got iv=%b dv=%b want %b %b", c, irv[0], drv[0], was_fetch, !was_fetch); end
                total++; if ((was_fetch ? ird[0] : drd[0]) !== mem_rdata) begin bad++;
                    $display("FAIL b2b_rdata c%0d: got %h want %h", c, was_fetch ? ird[0] : drd[0], mem_rdata); end
            end
            if (irv[0] === 1'b1) rv_count++;
            if (drv[0] === 1'b1) rv_count++;
            tick();
        end
        settle();
        if (irv[0] === 1'b1 || drv[0] === 1'b1) rv_count++;
        total++; if (rv_count != 8) begin bad++;
            $display("FAIL b2b_count: got %0d rvalids want 8", rv_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_2008;
        settle();
        total++; if (dgt[0] !== 1'b1) begin bad++;
            $display("FAIL rmid_gnt: got %b want 1", dgt[0]); end
        tick();
        idle_inputs();
        mem_rdata = 32'h1234_5678;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++; if (drv[k] !== 1'b0 || drd[k] !== 32'h0) begin bad++;
                $display("FAIL rmid_drop[%0d]: got dv=%b dd=%h want 0 0", k, drv[k], drd[k]); end
        end
        #1;
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            settle();
            for (int k = 0; k < 2; k++) begin
                total++; if (drv[k] !== 1'b0 || irv[k] !== 1'b0) begin bad++;
                    $display("FAIL rmid_after[%0d] n%0d: got dv=%b iv=%b want 0 0", k, n, drv[k], irv[k]); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (rst) model_reset();
            instr_req  = ($urandom_range(0, 3) != 0);
            instr_addr = $urandom;
            data_req   = ($urandom_range(0, 3) != 0);
            data_we    = $urandom_range(0, 1);
            data_addr  = $urandom;
            data_wdata = $urandom;
            mem_rdata  = $urandom;
            settle();
            for (int k = 0; k < 2; k++) begin
                total++; if (igt[k] !== e_igt[k] || dgt[k] !== e_dgt[k]) begin bad++;
                    $display("FAIL rnd_gnt[%0d] n%0d: got ig=%b dg=%b want %b %b", k, n, igt[k], dgt[k], e_igt[k], e_dgt[k]); end
                total++; if (mreq[k] !== e_mreq[k] || mwe[k] !== e_mwe[k]) begin bad++;
                    $display("FAIL rnd_req[%0d] n%0d: got req=%b we=%b want %b %b", k, n, mreq[k], mwe[k], e_mreq[k], e_mwe[k]); end
                total++; if (maddr[k] !== e_maddr[k] || mwdata[k] !== e_mwd[k]) begin bad++;
                    $display("FAIL rnd_mem[%0d] n%0d: got a=%h wd=%h want %h %h", k, n, maddr[k], mwdata[k], e_maddr[k], e_mwd[k]); end
                total++; if (irv[k] !== e_irv[k] || ird[k] !== e_ird[k]) begin bad++;
                    $display("FAIL rnd_iresp[%0d] n%0d: got v=%b d=%h want %b %h", k, n, irv[k], ird[k], e_irv[k], e_ird[k]); end
                total++; if (drv[k] !== e_drv[k] || drd[k] !== e_drd[k]) begin bad++;
                    $display("FAIL rnd_dresp[%0d] n%0d: got v=%b d=%h want %b %h", k, n, drv[k], drd[k], e_drv[k], e_drd[k]); end
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        mem_rdata = 32'h0;
        test_reset();
        test_fetch();
        test_contention();
        test_store();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
